conv_input_streamer: RTL and testbench

Producer side of the convolution input buffer interface. Reads a W×W 16-bit feature map from single-port SRAM and streams it, zero-padded by one pixel on every side, into the convolution input buffer. It drives in/CIB_Shift/CIB_Zero_Input in row-major padded order. It also flags the cycles on which the buffer's 3×3 output holds a valid window, honouring stride 1 or stride 2.

---
 rtl/conv_input_streamer.sv | 165 ++++++++++++++++
 tb/tb_conv_input_streamer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_input_streamer.sv
// Streams a zero-padded WxW SRAM map into the conv input buffer: issue at 1+k, shift at 2+k, window flag at 3+k.
// stall freezes every stage for the cycle and suppresses reads, shifts and window flags; no data lost or repeated.
module conv_input_streamer #(
    parameter int MAX_W = 16,
    parameter int AW    = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          start,
    input  logic [4:0]    cfg_width,
    input  logic          cfg_stride2,
    input  logic          stall,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [15:0]   mem_rdata,
    output logic [15:0]   cib_in,
    output logic          cib_shift,
    output logic          cib_zero_input,
    output logic          win_valid,
    output logic [3:0]    win_row,
    output logic [3:0]    win_col,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_FIN} state_t;

    state_t state_q, state_d;

    logic [4:0]    w_q;
    logic          stride2_q;
    logic          bad_q;
    logic [4:0]    r_q, c_q;
    logic [4:0]    w_p1;
    logic          pad_now;
    logic          step;
    logic          last_pos;
    logic [AW-1:0] addr_now;

    logic          s0_vld, s0_pad, s0_rd;
    logic [4:0]    s0_r, s0_c;
    logic [AW-1:0] s0_addr;
    logic          s1_vld, s1_pad;
    logic [4:0]    s1_r, s1_c;
    logic          win_ok;
    logic          s2_win;
    logic [3:0]    row_q, col_q;

    logic          rd_live;
    logic          have_hold;
    logic [15:0]   hold_dat;

    assign w_p1     = w_q + 5'd1;
    assign pad_now  = (r_q == 5'd0) || (r_q == w_p1) || (c_q == 5'd0) || (c_q == w_p1);
    assign step     = (state_q == S_STREAM) && !bad_q && !stall;
    assign last_pos = (r_q == w_p1) && (c_q == w_p1);
    assign addr_now = AW'(r_q - 5'd1) * AW'(w_q) + AW'(c_q - 5'd1);
    // (r-2),(c-2) even is the same as r,c even
    assign win_ok   = (s1_r >= 5'd2) && (s1_c >= 5'd2) &&
                      (!stride2_q || (!s1_r[0] && !s1_c[0]));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_STREAM;
            S_STREAM: begin
                if (bad_q)                 state_d = S_DRAIN;
                else if (step && last_pos) state_d = S_DRAIN;
            end
            S_DRAIN:  if (!stall && !s0_vld && !s1_vld) state_d = S_FIN;
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            w_q       <= '0;
            stride2_q <= 1'b0;
            bad_q     <= 1'b0;
            r_q       <= '0;
            c_q       <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                w_q       <= cfg_width;
                stride2_q <= cfg_stride2;
                bad_q     <= (cfg_width == 5'd0) || (int'(cfg_width) > MAX_W);
                r_q       <= '0;
                c_q       <= '0;
            end else if (step) begin
                if (c_q == w_p1) begin
                    c_q <= '0;
                    r_q <= r_q + 5'd1;
                end else begin
                    c_q <= c_q + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s0_vld  <= 1'b0;
            s0_pad  <= 1'b0;
            s0_rd   <= 1'b0;
            s0_r    <= '0;
            s0_c    <= '0;
            s0_addr <= '0;
            s1_vld  <= 1'b0;
            s1_pad  <= 1'b0;
            s1_r    <= '0;
            s1_c    <= '0;
            s2_win  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else if (!stall) begin
            s0_vld  <= step;
            s0_pad  <= pad_now;
            s0_rd   <= step && !pad_now;
            s0_r    <= r_q;
            s0_c    <= c_q;
            s0_addr <= addr_now;
            s1_vld  <= s0_vld;
            s1_pad  <= s0_pad;
            s1_r    <= s0_r;
            s1_c    <= s0_c;
            s2_win  <= s1_vld && win_ok;
            if (s1_vld) begin
                row_q <= 4'(s1_r - 5'd2);
                col_q <= 4'(s1_c - 5'd2);
            end
        end
    end

    // SRAM data is only valid for one cycle; park it if a stall lands on that cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_live   <= 1'b0;
            have_hold <= 1'b0;
            hold_dat  <= '0;
        end else begin
            rd_live <= mem_rd_en;
            if (stall && rd_live) begin
                hold_dat  <= mem_rdata;
                have_hold <= 1'b1;
            end else if (!stall) begin
                have_hold <= 1'b0;
            end
        end
    end

    assign mem_rd_en      = s0_rd && !stall;
    assign mem_addr       = s0_addr;
    assign cib_shift      = s1_vld && !stall;
    assign cib_zero_input = cib_shift && s1_pad;
    assign cib_in         = (s1_vld && !s1_pad) ? (have_hold ? hold_dat : mem_rdata) : 16'd0;
    assign win_valid      = s2_win && !stall;
    assign win_row        = row_q;
    assign win_col        = col_q;
    assign busy           = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign done           = (state_q == S_FIN);

endmodule

// File: tb/tb_conv_input_streamer.sv
// Scoreboard bench for conv_input_streamer: stimulus pushes expected reads, shifts and windows; a monitor pops and compares.
module tb_conv_input_streamer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  cfg_width = '0;
    logic        cfg_stride2 = 1'b0;
    logic        stall = 1'b0;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = '0;
    logic [15:0] cib_in;
    logic        cib_shift;
    logic        cib_zero_input;
    logic        win_valid;
    logic [3:0]  win_row;
    logic [3:0]  win_col;
    logic        busy;
    logic        done;

    always #5 CLK = ~CLK;

    conv_input_streamer #(.MAX_W(16), .AW(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .cfg_width(cfg_width),
        .cfg_stride2(cfg_stride2), .stall(stall), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .cib_in(cib_in),
        .cib_shift(cib_shift), .cib_zero_input(cib_zero_input),
        .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .busy(busy), .done(done)
    );

    // SRAM: data valid for exactly one cycle after a read, junk otherwise
    logic [15:0] mem [256];
    always @(posedge CLK) mem_rdata <= mem_rd_en ? mem[mem_addr] : 16'hDEAD;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { logic [15:0] dat; logic zero; } shift_t;
    typedef struct { int row; int col; int centre; int cyc; } win_t;

    shift_t      shift_q [$];
    win_t        win_q [$];
    int          addr_q [$];
    int          stream [$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          frame_w = 0;
    int          t0 = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          shift_cnt = 0;
    int          zero_cnt = 0;
    int          win_cnt = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    shift_t se;
    win_t   we;
    int     ea;
    int     idx;

    always @(negedge CLK) begin
        if (RST_N) begin
            if (mem_rd_en) begin
                if (addr_q.size() == 0) check("unexpected_read", mem_rd_en, 0);
                else begin
                    ea = addr_q.pop_front();
                    check("mem_addr", mem_addr, ea);
                end
            end
            if (cib_shift) begin
                shift_cnt++;
                if (cib_zero_input) zero_cnt++;
                stream.push_back(int'(cib_in));
                if (shift_q.size() == 0) check("unexpected_shift", cib_shift, 0);
                else begin
                    se = shift_q.pop_front();
                    check("cib_zero_input", cib_zero_input, se.zero);
                    check("cib_in", cib_in, se.dat);
                end
            end
            if (win_valid) begin
                win_cnt++;
                if (win_q.size() == 0) check("unexpected_window", win_valid, 0);
                else begin
                    we = win_q.pop_front();
                    check("win_row", win_row, we.row);
                    check("win_col", win_col, we.col);
                    idx = (we.row + 1) * (frame_w + 2) + we.col + 1;
                    check("win_centre", (idx < stream.size()) ? stream[idx] : -1, we.centre);
                    if (we.cyc >= 0) check("win_cycle", cyc - t0, we.cyc);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc - t0;
            end
        end
    end

    function automatic bit w_legal(input int w);
        return (w >= 1) && (w <= 16);
    endfunction

    task automatic expect_frame(input int w, input bit s2, input bit chk_cyc);
        bit pad;
        int a;
        frame_w = w;
        stream.delete(); shift_q.delete(); win_q.delete(); addr_q.delete();
        shift_cnt = 0; zero_cnt = 0; win_cnt = 0;
        if (w_legal(w)) begin
            for (int r = 0; r <= w + 1; r++) begin
                for (int c = 0; c <= w + 1; c++) begin
                    pad = (r == 0) || (r == w + 1) || (c == 0) || (c == w + 1);
                    a = (r - 1) * w + (c - 1);
                    if (!pad) addr_q.push_back(a);
                    shift_q.push_back('{dat: pad ? 16'd0 : mem[a], zero: pad});
                    if (r >= 2 && c >= 2 && (!s2 || ((r - 2) % 2 == 0 && (c - 2) % 2 == 0)))
                        win_q.push_back('{row: r - 2, col: c - 2, centre: int'(mem[(r - 2) * w + (c - 2)]),
                                          cyc: chk_cyc ? 3 + r * (w + 2) + c : -1});
                end
            end
        end
    endtask

    task automatic kick(input int w, input bit s2);
        @(posedge CLK); #1;
        cfg_width = 5'(w); cfg_stride2 = s2; start = 1'b1;
        @(posedge CLK); #1;
        t0 = cyc;
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic run_frame(input int w, input bit s2, input bit do_stall, input bit chk_cyc,
                             input int restart_at);
        int k, m, stalls, burst, d0, exp_wins;
        k = w_legal(w) ? (w + 2) * (w + 2) : 0;
        exp_wins = !w_legal(w) ? 0 : (s2 ? ((w + 1) / 2) * ((w + 1) / 2) : w * w);
        expect_frame(w, s2, chk_cyc);
        d0 = done_cnt;
        kick(w, s2);
        m = 0; stalls = 0; burst = 0;
        while (done_cnt == d0 && m < 3000) begin
            start = (m == restart_at);
            if (start) cfg_width = 5'd5;
            stall = 1'b0;
            if (do_stall && m < k) begin
                if (burst == 0 && $urandom_range(0, 4) == 0) burst = $urandom_range(1, 5);
                if (burst > 0) begin
                    stall = 1'b1; burst--; stalls++;
                end
            end
            @(posedge CLK); #1;
            m++;
        end
        start = 1'b0; stall = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check("done_pulses", done_cnt - d0, 1);
        check("done_cycle", done_cyc, w_legal(w) ? 3 + k + stalls : 2);
        check("busy_after_done", busy, 0);
        check("shift_count", shift_cnt, k);
        check("zero_count", zero_cnt, w_legal(w) ? k - w * w : 0);
        check("window_count", win_cnt, exp_wins);
        check("leftover_reads", addr_q.size(), 0);
        check("leftover_shifts", shift_q.size(), 0);
        check("leftover_windows", win_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 37 + 5);
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", {mem_rd_en, mem_addr, cib_in, cib_shift, cib_zero_input,
                                win_valid, win_row, win_col, busy, done}, 0);
        RST_N = 1'b1;

        run_frame(3, 1'b0, 1'b0, 1'b1, -1);

        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        run_frame(4, 1'b1, 1'b0, 1'b1, -1);

        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257 + 3);
        run_frame(16, 1'b0, 1'b1, 1'b0, -1);

        run_frame(3, 1'b0, 1'b0, 1'b1, 5);
        run_frame(0, 1'b0, 1'b0, 1'b0, -1);
        run_frame(17, 1'b1, 1'b0, 1'b0, -1);

        // abort a W=8 frame with reset, then run it cleanly
        expect_frame(8, 1'b0, 1'b0);
        kick(8, 1'b0);
        repeat (30) @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        check("abort_outputs", {mem_rd_en, mem_addr, cib_in, cib_shift, cib_zero_input,
                                win_valid, win_row, win_col, busy, done}, 0);
        begin
            int d0;
            d0 = done_cnt;
            repeat (20) @(posedge CLK);
            #1;
            RST_N = 1'b1;
            repeat (20) @(posedge CLK);
            #1;
            check("no_done_after_abort", done_cnt - d0, 0);
            check("idle_after_abort", busy, 0);
        end
        run_frame(8, 1'b0, 1'b1, 1'b0, -1);

        run_frame(1, 1'b1, 1'b0, 1'b1, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
